// File: rtl/mode_encoder.sv
// Mode encoder: synchronizes and debounces five raw operator buttons and turns
// their press events into a one-hot mode code plus a one-cycle change pulse.
module mode_encoder #(
    parameter int DEBOUNCE_N = 4,
    parameter int CNT_W      = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_emg,
    input  logic btn_ngt,
    input  logic btn_mnt,
    input  logic btn_ped,
    input  logic btn_clr,
    output logic P3,
    output logic P2,
    output logic P1,
    output logic P0,
    output logic mode_chg
);

    localparam int NB    = 5;
    localparam int B_CLR = 0;
    localparam int B_EMG = 1;
    localparam int B_NGT = 2;
    localparam int B_MNT = 3;
    localparam int B_PED = 4;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_N - 1);
    localparam logic [3:0]       HOLD_LAST = 4'd15;

    typedef enum logic [3:0] {
        MODE_AUTO = 4'b0000,
        MODE_EMG  = 4'b1000,
        MODE_NGT  = 4'b0100,
        MODE_MNT  = 4'b0010,
        MODE_PED  = 4'b0001
    } mode_t;

    logic [NB-1:0]    btn_raw_s;
    logic [NB-1:0]    sync1_q, sync1_d;
    logic [NB-1:0]    sync2_q, sync2_d;
    logic [NB-1:0]    level_q, level_d;
    logic [NB-1:0]    level_dly_q, level_dly_d;
    logic [NB-1:0]    press_s;
    logic [CNT_W-1:0] cnt_q [NB];
    logic [CNT_W-1:0] cnt_d [NB];
    mode_t            mode_q, mode_d;
    mode_t            mode_prev_q, mode_prev_d;
    logic [3:0]       hold_q, hold_d;
    logic             mode_chg_q, mode_chg_d;

    assign btn_raw_s = {btn_ped, btn_mnt, btn_ngt, btn_emg, btn_clr};

    // Two-flop synchronizer chain for every raw button.
    always_comb begin
        sync1_d = btn_raw_s;
        sync2_d = sync1_q;
    end

    // Per-button debounce: the level flips only after DEBOUNCE_N consecutive
    // disagreeing samples; any agreeing sample restarts the count.
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < NB; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    level_d[i] = ~level_q[i];
                    cnt_d[i]   = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    // Press events are rising edges of the registered debounced level.
    always_comb begin
        level_dly_d = level_q;
        press_s     = level_q & ~level_dly_q;
    end

    // Mode selection: one event per cycle by priority; EMG is only left via clr.
    always_comb begin
        mode_d = mode_q;
        if (press_s[B_CLR]) begin
            mode_d = MODE_AUTO;
        end else if (press_s[B_EMG]) begin
            mode_d = MODE_EMG;
        end else if (mode_q == MODE_EMG) begin
            mode_d = MODE_EMG;
        end else if (press_s[B_NGT]) begin
            mode_d = (mode_q == MODE_NGT) ? MODE_AUTO : MODE_NGT;
        end else if (press_s[B_MNT]) begin
            mode_d = (mode_q == MODE_MNT) ? MODE_AUTO : MODE_MNT;
        end else if (press_s[B_PED]) begin
            mode_d = (mode_q == MODE_PED) ? MODE_AUTO : MODE_PED;
        end else if (mode_q == MODE_PED) begin
            mode_d = (hold_q == HOLD_LAST) ? MODE_AUTO : MODE_PED;
        end else begin
            mode_d = mode_q;
        end
    end

    // PED hold timer: starts at zero on entry, advances only while PED persists.
    always_comb begin
        hold_d = 4'd0;
        if ((mode_q == MODE_PED) && (mode_d == MODE_PED)) begin
            hold_d = hold_q + 4'd1;
        end else begin
            hold_d = 4'd0;
        end
    end

    // Change pulse compares the code against its one-cycle-old copy, so it
    // lands in the cycle after the code moved and never fires on a reload.
    always_comb begin
        mode_prev_d = mode_q;
        mode_chg_d  = (mode_q != mode_prev_q);
    end

    // State registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            level_q     <= '0;
            level_dly_q <= '0;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= '0;
            end
            mode_q      <= MODE_AUTO;
            mode_prev_q <= MODE_AUTO;
            hold_q      <= 4'd0;
            mode_chg_q  <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            level_q     <= level_d;
            level_dly_q <= level_dly_d;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            mode_q      <= mode_d;
            mode_prev_q <= mode_prev_d;
            hold_q      <= hold_d;
            mode_chg_q  <= mode_chg_d;
        end
    end

    assign {P3, P2, P1, P0} = mode_q;
    assign mode_chg         = mode_chg_q;

endmodule
